// File: rtl/s_to_p_gear.sv
// Purpose : serial-to-parallel gearbox, packs IN_WIDTH-bit beats into OUT_RATIO-beat words.
// Latency : 1 cycle from the completing beat to valid_b.
// Backpr. : full valid/ready on both sides; one spare word is held in acc, and ready_a drops while it waits.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   valid_a/data_a/last_a     input beat; last_a closes a partial word
//   ready_a                   registered, high whenever acc has room
//   valid_b/ready_b           output word handshake
//   data_b                    packed word, unfilled slots zero
//   len_b                     beats in word, 1..OUT_RATIO
//   word_cnt                  output word counter, present only with S_TO_P_GEAR_CNT_EN
module s_to_p_gear #(
  parameter int IN_WIDTH  = 1,
  parameter int OUT_RATIO = 6,
  parameter int MSB_FIRST = 0,
  localparam int OUT_WIDTH = IN_WIDTH * OUT_RATIO,
  localparam int CNT_W     = $clog2(OUT_RATIO + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_a,
  input  logic [IN_WIDTH-1:0]  data_a,
  input  logic                 last_a,
  output logic                 ready_a,
  output logic                 valid_b,
  input  logic                 ready_b,
  output logic [OUT_WIDTH-1:0] data_b,
  output logic [CNT_W-1:0]     len_b
`ifdef S_TO_P_GEAR_CNT_EN
  ,
  output logic [15:0]          word_cnt
`endif
);

  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] acc_ins;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 acc_full;
  logic                 out_free;
  logic                 in_xfer;
  logic                 complete;

  assign out_free = ~valid_b | ready_b;
  assign in_xfer  = valid_a & ready_a;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign complete = in_xfer & ((cnt == CNT_W'(OUT_RATIO - 1)) | last_a);

  // acc with the current beat dropped into slot cnt; unfilled slots are
  // already zero because acc is cleared after every completed word.
  always_comb begin
    acc_ins = acc;
    for (int k = 0; k < OUT_RATIO; k++) begin
      if (cnt == CNT_W'(k)) begin
        acc_ins[((MSB_FIRST != 0) ? (OUT_RATIO - 1 - k) : k) * IN_WIDTH +: IN_WIDTH] = data_a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_a  <= 1'b0;
      valid_b  <= 1'b0;
      data_b   <= '0;
      len_b    <= '0;
      cnt      <= '0;
      acc      <= '0;
      acc_full <= 1'b0;
`ifdef S_TO_P_GEAR_CNT_EN
      word_cnt <= '0;
`endif
    end else begin
      // ready_a tracks the next value of acc_full; branches below override.
      ready_a <= ~acc_full;
      if (valid_b && ready_b) valid_b <= 1'b0;

      if (acc_full) begin
        // Buffered word: cnt still holds its length.
        if (out_free) begin
          data_b   <= acc;
          len_b    <= cnt;
          valid_b  <= 1'b1;
          acc      <= '0;
          cnt      <= '0;
          acc_full <= 1'b0;
          ready_a  <= 1'b1;
        end
      end else if (in_xfer) begin
        if (complete && out_free) begin
          // Straight to the output stage; valid_b stays up if a word just left.
          data_b  <= acc_ins;
          len_b   <= cnt_inc;
          valid_b <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
        end else if (complete) begin
          acc      <= acc_ins;
          cnt      <= cnt_inc;
          acc_full <= 1'b1;
          ready_a  <= 1'b0;
        end else begin
          acc <= acc_ins;
          cnt <= cnt_inc;
        end
      end

`ifdef S_TO_P_GEAR_CNT_EN
      if (valid_b && ready_b) word_cnt <= word_cnt + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_s_to_p_gear.sv
module tb_s_to_p_gear;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  // shared stimulus for the LSB-first (u0) and MSB-first (u1) 1x6 gearboxes
  logic       valid_a, data_a, last_a, ready_b;
  logic       ready_a0, valid_b0, ready_a1, valid_b1;
  logic [5:0] data_b0, data_b1;
  logic [2:0] len_b0, len_b1;
  // 4x2 gearbox
  logic       valid_a2, last_a2, ready_b2, ready_a2, valid_b2;
  logic [3:0] data_a2;
  logic [7:0] data_b2;
  logic [1:0] len_b2;
`ifdef S_TO_P_GEAR_CNT_EN
  logic [15:0] word_cnt0, word_cnt1, word_cnt2;
`endif

  int checks = 0;
  int errors = 0;

  s_to_p_gear #(.IN_WIDTH(1), .OUT_RATIO(6), .MSB_FIRST(0)) u0 (
    .clk(clk), .rst(rst), .valid_a(valid_a), .data_a(data_a), .last_a(last_a),
    .ready_a(ready_a0), .valid_b(valid_b0), .ready_b(ready_b), .data_b(data_b0), .len_b(len_b0)
`ifdef S_TO_P_GEAR_CNT_EN
    , .word_cnt(word_cnt0)
`endif
  );

  s_to_p_gear #(.IN_WIDTH(1), .OUT_RATIO(6), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .valid_a(valid_a), .data_a(data_a), .last_a(last_a),
    .ready_a(ready_a1), .valid_b(valid_b1), .ready_b(ready_b), .data_b(data_b1), .len_b(len_b1)
`ifdef S_TO_P_GEAR_CNT_EN
    , .word_cnt(word_cnt1)
`endif
  );

  s_to_p_gear #(.IN_WIDTH(4), .OUT_RATIO(2), .MSB_FIRST(0)) u2 (
    .clk(clk), .rst(rst), .valid_a(valid_a2), .data_a(data_a2), .last_a(last_a2),
    .ready_a(ready_a2), .valid_b(valid_b2), .ready_b(ready_b2), .data_b(data_b2), .len_b(len_b2)
`ifdef S_TO_P_GEAR_CNT_EN
    , .word_cnt(word_cnt2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic d, input logic l);
    valid_a = v;
    data_a  = d;
    last_a  = l;
    tick();
  endtask

  logic [5:0] bits;

  initial begin
    rst = 1'b1; valid_a = 1'b0; data_a = 1'b0; last_a = 1'b0; ready_b = 1'b1;
    valid_a2 = 1'b0; data_a2 = 4'h0; last_a2 = 1'b0; ready_b2 = 1'b1;

    // reset state
    tick();
    chk("rst_ready_a", ready_a0, 0);
    chk("rst_valid_b", valid_b0, 0);
    chk("rst_data_b", data_b0, 0);
    chk("rst_len_b", len_b0, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready_a", ready_a0, 1);

    // 1/2: beats 1,0,1,1,0,0
    bits = 6'b001101;
    for (int i = 0; i < 5; i++) drv(1'b1, bits[i], 1'b0);
    chk("t1_no_early_valid", valid_b0, 0);
    drv(1'b1, bits[5], 1'b0);
    chk("t1_valid_b", valid_b0, 1);
    chk("t1_data_lsb", data_b0, 6'b001101);
    chk("t1_len", len_b0, 6);
    chk("t2_data_msb", data_b1, 6'b101100);
    chk("t2_len", len_b1, 6);
    drv(1'b0, 1'b0, 1'b1); // last_a with valid_a=0 is ignored
    chk("t1_drained", valid_b0, 0);
    chk("t1_ignored_last", valid_b0 | valid_b1, 0);

    // 3: partial word of 3, then a 1-beat word from slot 0
    drv(1'b1, 1'b1, 1'b0);
    drv(1'b1, 1'b1, 1'b0);
    drv(1'b1, 1'b1, 1'b1);
    chk("t3_data_lsb", data_b0, 6'b000111);
    chk("t3_len", len_b0, 3);
    chk("t3_data_msb", data_b1, 6'b111000);
    // back-to-back 1-beat words: valid_b never drops
    drv(1'b1, 1'b1, 1'b1);
    chk("t3_b2b1_valid", valid_b0, 1);
    chk("t3_b2b1_data", data_b0, 6'b000001);
    chk("t3_b2b1_len", len_b0, 1);
    chk("t3_b2b1_msb", data_b1, 6'b100000);
    drv(1'b1, 1'b0, 1'b1);
    chk("t3_b2b2_valid", valid_b0, 1);
    chk("t3_b2b2_data", data_b0, 6'b000000);
    drv(1'b1, 1'b1, 1'b1);
    chk("t3_b2b3_data", data_b0, 6'b000001);
    chk("t3_b2b_ready", ready_a0, 1);
    // last_a on slot 5 is a normal full word
    for (int i = 0; i < 5; i++) drv(1'b1, 1'b1, 1'b0);
    drv(1'b1, 1'b1, 1'b1);
    chk("t3_full_last_data", data_b0, 6'b111111);
    chk("t3_full_last_len", len_b0, 6);
    drv(1'b0, 1'b0, 1'b0);

    // 4: backpressure, 12 beats with ready_b=0
    ready_b = 1'b0;
    bits = 6'b000001;
    for (int i = 0; i < 6; i++) drv(1'b1, bits[i], 1'b0);
    chk("t4_ready_mid", ready_a0, 1);
    bits = 6'b100010;
    for (int i = 0; i < 6; i++) drv(1'b1, bits[i], 1'b0);
    valid_a = 1'b0;
    chk("t4_ready_a_low", ready_a0, 0);
    chk("t4_word1", data_b0, 6'b000001);
    chk("t4_valid_held", valid_b0, 1);
    tick();
    chk("t4_word1_stable", data_b0, 6'b000001);
    chk("t4_ready_a_still_low", ready_a0, 0);
    ready_b = 1'b1;
    tick();
    ready_b = 1'b0;
    chk("t4_word2", data_b0, 6'b100010);
    chk("t4_word2_len", len_b0, 6);
    chk("t4_word2_valid", valid_b0, 1);
    chk("t4_ready_a_back", ready_a0, 1);
    ready_b = 1'b1;
    tick();
    chk("t4_drained", valid_b0, 0);

    // 5: reset mid-word
    drv(1'b1, 1'b1, 1'b0);
    drv(1'b1, 1'b1, 1'b0);
    drv(1'b1, 1'b1, 1'b0);
    valid_a = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_ready_a", ready_a0, 0);
    chk("t5_valid_b", valid_b0, 0);
    chk("t5_data_b", data_b0, 0);
    chk("t5_len_b", len_b0, 0);
    tick();
    bits = 6'b100000;
    for (int i = 0; i < 6; i++) drv(1'b1, bits[i], 1'b0);
    valid_a = 1'b0;
    chk("t5_no_stale", data_b0, 6'b100000);
    chk("t5_len", len_b0, 6);

    // 6: 4x2, A,5 continuous with ready_b=1
    for (int w = 0; w < 3; w++) begin
      valid_a2 = 1'b1; data_a2 = 4'hA;
      tick();
      chk("t6_gap_valid", valid_b2, 0);
      chk("t6_ready", ready_a2, 1);
`ifdef S_TO_P_GEAR_CNT_EN
      chk("t6_word_cnt_step", word_cnt2, w);
`endif
      data_a2 = 4'h5;
      tick();
      chk("t6_valid", valid_b2, 1);
      chk("t6_data", data_b2, 8'h5A);
      chk("t6_len", len_b2, 2);
    end
    valid_a2 = 1'b0;
    tick();
    chk("t6_drained", valid_b2, 0);
`ifdef S_TO_P_GEAR_CNT_EN
    chk("t6_word_cnt", word_cnt2, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
